memory_1r1w_driver: RTL and testbench

// - Initiator for a 1r1w memory: takes a valid/ready request stream of reads and posted writes.
// - Drives the memory write port (adra/da/wema/wea/mea) and read port (adrb/meb); captures qb.
// - Returns read data, in order, on a valid/ready response stream.
// - Sits between bench sequencers/BFMs and memory_1r1w* models or real macros, on one clock.

---
 rtl/memory_1r1w_driver_pkg.sv | 14 +
 rtl/memory_1r1w_driver_if.sv | 40 ++++
 rtl/memory_1r1w_driver_fifo.sv | 63 ++++++
 rtl/memory_1r1w_driver.sv | 124 ++++++++++++
 tb/tb_memory_1r1w_driver.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_1r1w_driver_pkg.sv
// Shared types and default parameters for the 1r1w memory request driver.
package memory_1r1w_driver_pkg;

  typedef enum logic {
    PZTB_MEM_READ  = 1'b0,
    PZTB_MEM_WRITE = 1'b1
  } pztb_mem_cmd;

  localparam int unsigned DEF_DATAW        = 32;
  localparam int unsigned DEF_WORDW        = 1024;
  localparam int unsigned DEF_READ_LATENCY = 1;
  localparam int unsigned DEF_RSP_DEPTH    = 4;

endpackage

// File: rtl/memory_1r1w_driver_if.sv
// Request/response streams plus the 1r1w memory pins; master = driver side, slave = environment side.
interface memory_1r1w_driver_if #(
  parameter int DATAW = 32,
  parameter int ADDRW = 10
) ();
  import memory_1r1w_driver_pkg::*;

  logic              req_valid;
  logic              req_ready;
  pztb_mem_cmd       req_command;
  logic [ADDRW-1:0]  req_address;
  logic [DATAW-1:0]  req_data;
  logic [DATAW-1:0]  req_mask;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATAW-1:0]  rsp_data;

  logic [ADDRW-1:0]  adra;
  logic [DATAW-1:0]  da;
  logic [DATAW-1:0]  wema;
  logic              wea;
  logic              mea;
  logic [ADDRW-1:0]  adrb;
  logic              meb;
  logic [DATAW-1:0]  qb;

  logic              idle;

  modport master (
    input  req_valid, req_command, req_address, req_data, req_mask, rsp_ready, qb,
    output req_ready, rsp_valid, rsp_data, adra, da, wema, wea, mea, adrb, meb, idle
  );

  modport slave (
    output req_valid, req_command, req_address, req_data, req_mask, rsp_ready, qb,
    input  req_ready, rsp_valid, rsp_data, adra, da, wema, wea, mea, adrb, meb, idle
  );

endinterface

// File: rtl/memory_1r1w_driver_fifo.sv
// Synchronous FIFO holding returned read data; head is combinational from storage, 1-cycle push-to-empty-deassert.
module memory_1r1w_driver_fifo #(
  parameter int DATAW = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [DATAW-1:0] din,
  input  logic             pop,
  output logic             empty,
  output logic             full,
  output logic [DATAW-1:0] head
);
  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [DATAW-1:0] mem_q [DEPTH];
  logic [DATAW-1:0] mem_d [DEPTH];
  logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNTW'(DEPTH));
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d = (wr_ptr_q == PTRW'(DEPTH - 1)) ? '0 : wr_ptr_q + PTRW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTRW'(DEPTH - 1)) ? '0 : rd_ptr_q + PTRW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CNTW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/memory_1r1w_driver.sv
// Turns a read/posted-write request stream into registered 1r1w memory cycles and returns read data in order.
// Request-to-memory is 1 cycle; rsp_valid follows a read accept by 2+READ_LATENCY cycles; credits throttle reads.
module memory_1r1w_driver
  import memory_1r1w_driver_pkg::*;
#(
  parameter int DATAW        = DEF_DATAW,
  parameter int WORDW        = DEF_WORDW,
  parameter int READ_LATENCY = DEF_READ_LATENCY,
  parameter int RSP_DEPTH    = DEF_RSP_DEPTH
) (
  input logic                  clk,
  input logic                  rst,
  memory_1r1w_driver_if.master bus
);
  localparam int ADDRW = $clog2(WORDW);
  localparam int CRDW  = $clog2(RSP_DEPTH + 1);

  typedef logic [DATAW-1:0] data_t;
  typedef logic [ADDRW-1:0] addr_t;
  typedef logic [CRDW-1:0]  crd_t;

  localparam crd_t CRD_MAX = crd_t'(RSP_DEPTH);

  addr_t                   adra_q, adra_d, adrb_q, adrb_d;
  data_t                   da_q, da_d, wema_q, wema_d;
  logic                    wr_q, wr_d, meb_q, meb_d;
  logic [READ_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
  crd_t                    credits_q, credits_d;

  logic  req_ready_int, req_fire, rd_fire, wr_fire;
  logic  rsp_vld_int, rsp_fire;
  logic  fifo_push, fifo_empty, fifo_full;
  data_t fifo_head;

  always_comb begin
    req_ready_int = !rst && (credits_q != '0);
    req_fire      = bus.req_valid && req_ready_int;
    rd_fire       = req_fire && (bus.req_command == PZTB_MEM_READ);
    wr_fire       = req_fire && (bus.req_command == PZTB_MEM_WRITE);
    rsp_vld_int   = !rst && !fifo_empty;
    rsp_fire      = rsp_vld_int && bus.rsp_ready;

    wr_d   = wr_fire;
    meb_d  = rd_fire;
    adra_d = adra_q;
    da_d   = da_q;
    wema_d = wema_q;
    adrb_d = adrb_q;
    if (wr_fire) begin
      adra_d = bus.req_address;
      da_d   = bus.req_data;
      wema_d = bus.req_mask;
    end
    if (rd_fire) begin
      adrb_d = bus.req_address;
    end

    // Tracks which memory cycles will present valid qb, READ_LATENCY cycles after meb.
    rd_pipe_d[0] = meb_q;
    for (int i = 1; i < READ_LATENCY; i++) rd_pipe_d[i] = rd_pipe_q[i-1];

    credits_d = credits_q;
    if (rd_fire && !rsp_fire) begin
      credits_d = credits_q - crd_t'(1);
    end else if (rsp_fire && !rd_fire) begin
      credits_d = credits_q + crd_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q      <= 1'b0;
      meb_q     <= 1'b0;
      adra_q    <= '0;
      da_q      <= '0;
      wema_q    <= '0;
      adrb_q    <= '0;
      rd_pipe_q <= '0;
      credits_q <= CRD_MAX;
    end else begin
      wr_q      <= wr_d;
      meb_q     <= meb_d;
      adra_q    <= adra_d;
      da_q      <= da_d;
      wema_q    <= wema_d;
      adrb_q    <= adrb_d;
      rd_pipe_q <= rd_pipe_d;
      credits_q <= credits_d;
    end
  end

  // Every entry was pre-paid by a credit, so the push never meets a full FIFO.
  assign fifo_push = rd_pipe_q[READ_LATENCY-1];

  memory_1r1w_driver_fifo #(
    .DATAW (DATAW),
    .DEPTH (RSP_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (bus.qb),
    .pop   (rsp_fire),
    .empty (fifo_empty),
    .full  (fifo_full),
    .head  (fifo_head)
  );

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(fifo_push && fifo_full && !rsp_fire));

  assign bus.req_ready = req_ready_int;
  assign bus.rsp_valid = rsp_vld_int;
  assign bus.rsp_data  = rsp_vld_int ? fifo_head : '0;
  assign bus.idle      = !rst && (credits_q == CRD_MAX);
  assign bus.adra      = adra_q;
  assign bus.da        = da_q;
  assign bus.wema      = wema_q;
  assign bus.wea       = wr_q;
  assign bus.mea       = wr_q;
  assign bus.adrb      = adrb_q;
  assign bus.meb       = meb_q;

endmodule

// File: tb/tb_memory_1r1w_driver.sv
// Bench for memory_1r1w_driver: behavioural 1r1w memory, array reference model and per-feature scenario tasks.
module tb_memory_1r1w_driver;
  import memory_1r1w_driver_pkg::*;

  localparam int DW    = 32;
  localparam int WORDS = 1024;
  localparam int AW    = 10;
  localparam int RL    = 1;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  memory_1r1w_driver_if #(.DATAW(DW), .ADDRW(AW)) bus ();

  memory_1r1w_driver #(
    .DATAW        (DW),
    .WORDW        (WORDS),
    .READ_LATENCY (RL),
    .RSP_DEPTH    (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 1r1w macro: masked write and registered read with RL cycles of latency.
  logic [DW-1:0] mem_arr [WORDS];
  logic [DW-1:0] qb_pipe [RL];
  always @(posedge clk) begin
    if (bus.mea && bus.wea)
      mem_arr[bus.adra] <= (mem_arr[bus.adra] & ~bus.wema) | (bus.da & bus.wema);
    qb_pipe[0] <= bus.meb ? mem_arr[bus.adrb] : 32'hDEAD_BEEF;
    for (int i = 1; i < RL; i++) qb_pipe[i] <= qb_pipe[i-1];
  end
  assign bus.qb = qb_pipe[RL-1];

  int            n_checks = 0;
  int            n_fail   = 0;
  int            outstanding = 0;
  logic          last_req_acc, last_rsp_acc;
  logic [DW-1:0] ref_mem [WORDS];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] got_q [$];

  function automatic logic [DW-1:0] pat(input int a);
    return 32'h5A00_0000 ^ (32'(a) * 32'h0001_0103);
  endfunction

  // Advance one cycle, updating the reference model from the handshakes at the coming edge.
  task automatic step();
    #1;
    last_req_acc = bus.req_valid && bus.req_ready;
    last_rsp_acc = bus.rsp_valid && bus.rsp_ready;
    if (rst) begin
      exp_q.delete();
      outstanding = 0;
    end else begin
      if (last_req_acc) begin
        if (bus.req_command == PZTB_MEM_WRITE) begin
          ref_mem[bus.req_address] = (ref_mem[bus.req_address] & ~bus.req_mask) |
                                     (bus.req_data & bus.req_mask);
        end else begin
          exp_q.push_back(ref_mem[bus.req_address]);
          outstanding++;
        end
      end
      if (last_rsp_acc) begin
        got_q.push_back(bus.rsp_data);
        outstanding--;
      end
    end
    @(negedge clk);
  endtask

  task automatic issue(input pztb_mem_cmd cmd, input int addr, input logic [DW-1:0] data,
                       input logic [DW-1:0] mask);
    bit acc = 0;
    bus.req_valid   = 1'b1;
    bus.req_command = cmd;
    bus.req_address = AW'(addr);
    bus.req_data    = data;
    bus.req_mask    = mask;
    for (int i = 0; i < 30 && !acc; i++) begin
      step();
      acc = last_req_acc;
    end
    bus.req_valid = 1'b0;
    n_checks++;
    if (!acc) begin
      n_fail++;
      $display("FAIL issue_timeout: addr %0h not accepted, got 0 want 1", addr);
    end
  endtask

  task automatic put(input int addr, input logic [DW-1:0] data);
    issue(PZTB_MEM_WRITE, addr, data, '1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    step();
    n_checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.idle, bus.mea, bus.wea, bus.meb, bus.adra, bus.adrb,
         bus.da, bus.wema, bus.rsp_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%0b vld=%0b idle=%0b mea=%0b meb=%0b want all 0",
               bus.req_ready, bus.rsp_valid, bus.idle, bus.mea, bus.meb);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if ({bus.req_ready, bus.idle, bus.rsp_valid} !== 3'b110) begin
      n_fail++;
      $display("FAIL reset_release: got rdy/idle/vld=%b want 110", {bus.req_ready, bus.idle, bus.rsp_valid});
    end
  endtask

  task automatic test_basic();
    got_q.delete(); exp_q.delete();
    bus.rsp_ready   = 1'b1;
    bus.req_valid   = 1'b1;
    bus.req_command = PZTB_MEM_WRITE;
    bus.req_address = 10'h010;
    bus.req_data    = 32'hCAFE_F00D;
    bus.req_mask    = '1;
    step();
    n_checks++;
    if ({bus.mea, bus.wea, bus.adra, bus.da, bus.wema} !== {2'b11, 10'h010, 32'hCAFE_F00D, 32'hFFFF_FFFF}) begin
      n_fail++;
      $display("FAIL basic_write_port: mea=%0b wea=%0b adra=%h da=%h want 1 1 010 cafef00d",
               bus.mea, bus.wea, bus.adra, bus.da);
    end
    bus.req_command = PZTB_MEM_READ;
    step();
    bus.req_valid = 1'b0;
    n_checks++;
    if ({bus.meb, bus.adrb, bus.wea, bus.mea} !== {1'b1, 10'h010, 2'b00}) begin
      n_fail++;
      $display("FAIL basic_read_port: meb=%0b adrb=%h wea=%0b want 1 010 0", bus.meb, bus.adrb, bus.wea);
    end
    step();
    n_checks++;
    if ({bus.rsp_valid, bus.meb} !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_early_rsp: rsp_valid=%0b meb=%0b want 0 0", bus.rsp_valid, bus.meb);
    end
    step();
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL basic_rsp: vld=%0b data=%h want 1 cafef00d", bus.rsp_valid, bus.rsp_data);
    end
    step();
    n_checks++;
    if (bus.idle !== 1'b1 || bus.rsp_valid !== 1'b0 || got_q.size() != 1) begin
      n_fail++;
      $display("FAIL basic_after: idle=%0b vld=%0b rsps=%0d want 1 0 1", bus.idle, bus.rsp_valid, got_q.size());
    end
  endtask

  task automatic test_masked();
    got_q.delete(); exp_q.delete();
    bus.rsp_ready = 1'b1;
    put(32'h20, '1);
    issue(PZTB_MEM_WRITE, 32'h20, 32'h0, 32'h0000_FFFF);
    issue(PZTB_MEM_READ, 32'h20, 32'h0, 32'h0);
    for (int i = 0; i < 20 && got_q.size() < 1; i++) step();
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 32'hFFFF_0000) begin
      n_fail++;
      $display("FAIL masked_rsp: rsps=%0d data=%h want 1 ffff0000", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 32'h0);
    end
  endtask

  task automatic test_throughput();
    int issued = 0;
    for (int a = 0; a < 100; a++) put(a, pat(a));
    got_q.delete(); exp_q.delete();
    bus.rsp_ready   = 1'b1;
    bus.req_command = PZTB_MEM_READ;
    for (int c = 0; c < 110; c++) begin
      bus.req_valid   = (issued < 100);
      bus.req_address = AW'(issued);
      if (issued < 100) begin
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL thru_ready: cycle %0d got 0 want 1", c);
        end
      end
      n_checks++;
      if (bus.rsp_valid !== ((c >= 2 + RL) && (c < 102 + RL))) begin
        n_fail++;
        $display("FAIL thru_rsp_valid: cycle %0d got %0b", c, bus.rsp_valid);
      end
      step();
      if (last_req_acc) issued++;
    end
    bus.req_valid = 1'b0;
    n_checks++;
    if (got_q.size() != 100) begin
      n_fail++;
      $display("FAIL thru_count: got %0d want 100", got_q.size());
    end
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== pat(i)) begin
        n_fail++;
        $display("FAIL thru_data: idx %0d got %h want %h", i, got_q[i], pat(i));
      end
    end
    n_checks++;
    if (bus.idle !== 1'b1) begin
      n_fail++;
      $display("FAIL thru_idle: got %0b want 1", bus.idle);
    end
  endtask

  task automatic test_backpressure();
    int accepted = 0;
    got_q.delete(); exp_q.delete();
    bus.rsp_ready   = 1'b0;
    bus.req_command = PZTB_MEM_READ;
    for (int c = 0; c < 10; c++) begin
      bus.req_valid   = (accepted < 6);
      bus.req_address = AW'(accepted);
      step();
      if (last_req_acc) accepted++;
    end
    bus.req_valid = 1'b0;
    n_checks++;
    if (accepted != DEPTH || bus.req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_accepts: got %0d ready=%0b want 4 0", accepted, bus.req_ready);
    end
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== pat(0)) begin
        n_fail++;
        $display("FAIL bp_hold: vld=%0b data=%h want 1 %h", bus.rsp_valid, bus.rsp_data, pat(0));
      end
      step();
    end
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 20 && got_q.size() < DEPTH; i++) step();
    n_checks++;
    if (got_q.size() != DEPTH) begin
      n_fail++;
      $display("FAIL bp_drain: got %0d want 4", got_q.size());
    end
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== pat(i)) begin
        n_fail++;
        $display("FAIL bp_order: idx %0d got %h want %h", i, got_q[i], pat(i));
      end
    end
  endtask

  task automatic test_simul_credit();
    got_q.delete(); exp_q.delete();
    bus.rsp_ready = 1'b0;
    for (int a = 10; a < 14; a++) issue(PZTB_MEM_READ, a, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) step();
    n_checks++;
    if (bus.req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL sim_full_ready: got %0b want 0", bus.req_ready);
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.req_valid   = 1'b1;
    bus.req_command = PZTB_MEM_READ;
    bus.req_address = 10'd14;
    step();
    n_checks++;
    if ({last_req_acc, last_rsp_acc, bus.req_ready} !== 3'b111) begin
      n_fail++;
      $display("FAIL sim_both: req/rsp/ready=%b want 111", {last_req_acc, last_rsp_acc, bus.req_ready});
    end
    bus.rsp_ready   = 1'b0;
    bus.req_address = 10'd15;
    step();
    bus.req_valid = 1'b0;
    n_checks++;
    if (last_req_acc !== 1'b1 || bus.req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL sim_zero: acc=%0b ready=%0b want 1 0", last_req_acc, bus.req_ready);
    end
    for (int i = 0; i < 5; i++) step();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 20 && got_q.size() < 6; i++) step();
    n_checks++;
    if (got_q.size() != 6) begin
      n_fail++;
      $display("FAIL sim_count: got %0d want 6", got_q.size());
    end
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== pat(10 + i)) begin
        n_fail++;
        $display("FAIL sim_data: idx %0d got %h want %h", i, got_q[i], pat(10 + i));
      end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] e, g;
    for (int a = 'h40; a < 'h50; a++) put(a, $urandom);
    got_q.delete(); exp_q.delete();
    for (int c = 0; c < 400; c++) begin
      bus.req_valid   = ($urandom_range(0, 3) != 0);
      bus.req_command = ($urandom_range(0, 1) != 0) ? PZTB_MEM_WRITE : PZTB_MEM_READ;
      bus.req_address = AW'('h40 + $urandom_range(0, 15));
      bus.req_data    = $urandom;
      bus.req_mask    = $urandom;
      bus.rsp_ready   = ($urandom_range(0, 3) != 0);
      n_checks++;
      if (bus.req_ready !== (outstanding < DEPTH) || bus.idle !== (outstanding == 0)) begin
        n_fail++;
        $display("FAIL rand_credit: cycle %0d ready=%0b idle=%0b outstanding=%0d",
                 c, bus.req_ready, bus.idle, outstanding);
      end
      step();
      while (got_q.size() > 0) begin
        g = got_q.pop_front();
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_extra_rsp: got %h want none", g);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin
            n_fail++;
            $display("FAIL rand_data: got %h want %h", g, e);
          end
        end
      end
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 30 && outstanding > 0; i++) step();
    n_checks++;
    if (got_q.size() != exp_q.size() || bus.idle !== 1'b1) begin
      n_fail++;
      $display("FAIL rand_drain: rsps=%0d exp=%0d idle=%0b", got_q.size(), exp_q.size(), bus.idle);
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL rand_tail: got %h want %h", g, e);
      end
    end
  endtask

  task automatic test_reset_midflight();
    got_q.delete(); exp_q.delete();
    bus.rsp_ready = 1'b0;
    for (int a = 'h40; a < 'h43; a++) issue(PZTB_MEM_READ, a, 32'h0, 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.rsp_valid, bus.meb, bus.idle} !== 3'b001) begin
      n_fail++;
      $display("FAIL rst_mid: vld/meb/idle=%b want 001", {bus.rsp_valid, bus.meb, bus.idle});
    end
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      n_checks++;
      if (bus.rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_stale: cycle %0d rsp_valid got 1 want 0", c);
      end
      step();
    end
    n_checks++;
    if (got_q.size() != 0 || bus.idle !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_after: rsps=%0d idle=%0b want 0 1", got_q.size(), bus.idle);
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_command = PZTB_MEM_READ;
    bus.req_address = '0;
    bus.req_data    = '0;
    bus.req_mask    = '0;
    bus.rsp_ready   = 1'b0;
    test_reset();
    test_basic();
    test_masked();
    test_throughput();
    test_backpressure();
    test_simul_credit();
    test_random();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
